// File: rtl/pipe_hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage core: RAW stall, branch flush, memory freeze, freeze watchdog.
// Latency: control outputs are combinational (same cycle); state/counters update on the next rising edge.
// Backpressure: mem_busy freezes every stage; a freeze lasting WDOG_LIMIT cycles halts the core until reset.
module pipe_hazard_sequencer #(
  parameter int CNT_W      = 16,
  parameter int WDOG_LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic             id_two_src,
  input  logic             id_valid,
  input  logic [4:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [4:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             fwd_en,
  input  logic             br_taken,
  input  logic             mem_busy,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             hazard_detected,
  output logic             freeze_back,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WD_W = $clog2(WDOG_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HAZ_STALL = 2'd1,
    ST_MEM_WAIT  = 2'd2,
    ST_HALT      = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Ungated decisions; the reset gate below forces them low while rst is asserted.
  logic fz_pc, fz_if_id, fl_if_id, haz, fz_back, hlt;

  logic exe_match, mem_match, raw_haz;
  logic wd_trip;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  always_comb begin
    exe_match = exe_wb_en && (exe_dest != 5'd0) &&
                ((exe_dest == id_src1) || (id_two_src && (exe_dest == id_src2)));
    mem_match = mem_wb_en && (mem_dest != 5'd0) &&
                ((mem_dest == id_src1) || (id_two_src && (mem_dest == id_src2)));
    // With forwarding only a load in EXE cannot be bypassed in time; without it
    // any producer in EXE or MEM must drain before decode reads the register file.
    raw_haz   = id_valid && (fwd_en ? (exe_match && exe_mem_r_en)
                                    : (exe_match || mem_match));
  end

  // Priority decision: halt, memory freeze, RAW stall, branch flush, run.
  always_comb begin
    fz_pc    = 1'b0;
    fz_if_id = 1'b0;
    fl_if_id = 1'b0;
    haz      = 1'b0;
    fz_back  = 1'b0;
    hlt      = 1'b0;
    state_d  = ST_RUN;
    if (state_q == ST_HALT) begin
      fz_pc    = 1'b1;
      fz_if_id = 1'b1;
      fz_back  = 1'b1;
      hlt      = 1'b1;
      state_d  = ST_HALT;
    end else if (mem_busy) begin
      // A pending branch stays frozen in decode and flushes once memory frees up.
      fz_pc    = 1'b1;
      fz_if_id = 1'b1;
      fz_back  = 1'b1;
      state_d  = ST_MEM_WAIT;
    end else if (raw_haz) begin
      // The branch decision used stale operands, so it is ignored this cycle.
      fz_pc    = 1'b1;
      fz_if_id = 1'b1;
      haz      = 1'b1;
      state_d  = ST_HAZ_STALL;
    end else if (br_taken) begin
      fl_if_id = 1'b1;
      state_d  = ST_RUN;
    end
    // The LIMIT-th consecutive frozen cycle sends the core to HALT.
    if (wd_trip) begin
      state_d = ST_HALT;
    end
  end

  // Watchdog counts consecutive frozen cycles outside HALT and holds inside it.
  always_comb begin
    wd_trip  = 1'b0;
    wd_cnt_d = wd_cnt_q;
    if (state_q != ST_HALT) begin
      if (fz_pc) begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
        wd_trip  = (wd_cnt_q == WD_W'(WDOG_LIMIT - 1));
      end else begin
        wd_cnt_d = '0;
      end
    end
  end

  // Saturating performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (fz_pc && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (fl_if_id && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State, watchdog and counters; reset returns to RUN without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      wd_cnt_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wd_cnt_q    <= wd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Controls are held low during reset regardless of the pipeline inputs.
  always_comb begin
    freeze_pc       = rst & fz_pc;
    freeze_if_id    = rst & fz_if_id;
    flush_if_id     = rst & fl_if_id;
    hazard_detected = rst & haz;
    freeze_back     = rst & fz_back;
    halted          = rst & hlt;
    stall_cnt       = stall_cnt_q;
    flush_cnt       = flush_cnt_q;
  end

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Directed bench for pipe_hazard_sequencer with an expected-response queue and a negedge monitor.
module tb_pipe_hazard_sequencer;

  localparam int CNT_W = 4;
  localparam int WDOG  = 8;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_src1, id_src2, exe_dest, mem_dest;
  logic id_two_src, id_valid, exe_wb_en, exe_mem_r_en, mem_wb_en, fwd_en, br_taken, mem_busy;
  logic freeze_pc, freeze_if_id, flush_if_id, hazard_detected, freeze_back, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_sequencer #(.CNT_W(CNT_W), .WDOG_LIMIT(WDOG)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_valid(id_valid),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .fwd_en(fwd_en),
    .br_taken(br_taken), .mem_busy(mem_busy),
    .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id), .flush_if_id(flush_if_id),
    .hazard_detected(hazard_detected), .freeze_back(freeze_back), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic [4:0] s1; logic [4:0] s2; logic two; logic vld;
    logic [4:0] ed; logic ewb; logic eld;
    logic [4:0] md; logic mwb; logic fwd; logic br; logic busy;
  } in_t;

  // fpc fif flush haz fback halted stall_cnt flush_cnt
  typedef struct packed {
    logic fpc; logic fif; logic fl; logic hz; logic fb; logic hl;
    logic [3:0] sc; logic [3:0] fc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;

  function automatic in_t mk(input int s1, input int s2, input bit two, input bit vld,
                             input int ed, input bit ewb, input bit eld,
                             input int md, input bit mwb, input bit fwd,
                             input bit br, input bit busy);
    in_t v;
    v.s1 = 5'(s1); v.s2 = 5'(s2); v.two = two; v.vld = vld;
    v.ed = 5'(ed); v.ewb = ewb; v.eld = eld;
    v.md = 5'(md); v.mwb = mwb; v.fwd = fwd; v.br = br; v.busy = busy;
    return v;
  endfunction

  function automatic exp_t ex(input bit fpc, input bit fif, input bit fl, input bit hz,
                              input bit fb, input bit hl, input int sc, input int fc);
    exp_t e;
    e.fpc = fpc; e.fif = fif; e.fl = fl; e.hz = hz; e.fb = fb; e.hl = hl;
    e.sc = 4'(sc); e.fc = 4'(fc);
    return e;
  endfunction

  task automatic drive(input in_t v);
    id_src1 = v.s1; id_src2 = v.s2; id_two_src = v.two; id_valid = v.vld;
    exe_dest = v.ed; exe_wb_en = v.ewb; exe_mem_r_en = v.eld;
    mem_dest = v.md; mem_wb_en = v.mwb; fwd_en = v.fwd;
    br_taken = v.br; mem_busy = v.busy;
  endtask

  // One stimulus cycle: apply inputs just after the edge, queue the expected response.
  task automatic cyc(input string nm, input in_t v, input exp_t e);
    @(posedge clk);
    #1;
    drive(v);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, got, req);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(mk(0,0,0,0, 0,0,0, 0,0,0, 0,0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: every cycle with a pending expectation, compare the whole output bundle.
  initial begin
    exp_t  e;
    exp_t  got;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        got = {freeze_pc, freeze_if_id, flush_if_id, hazard_detected, freeze_back, halted,
               stall_cnt, flush_cnt};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL %s: got fpc%b fif%b fl%b hz%b fb%b hl%b sc%0d fc%0d required fpc%b fif%b fl%b hz%b fb%b hl%b sc%0d fc%0d",
                   nm, got.fpc, got.fif, got.fl, got.hz, got.fb, got.hl, got.sc, got.fc,
                   e.fpc, e.fif, e.fl, e.hz, e.fb, e.hl, e.sc, e.fc);
        end
      end
    end
  end

  initial begin
    in_t idle;
    in_t busy;
    int  n;
    int  t;
    idle = mk(0,0,0,0, 0,0,0, 0,0,0, 0,0);
    busy = mk(0,0,0,1, 0,0,0, 0,0,0, 1,1);
    rst = 1'b0;
    // Reset state with hazard-producing inputs: everything must stay low.
    drive(mk(5,0,0,1, 5,1,1, 0,0,1, 1,1));
    #12;
    chk("rst_freeze_pc",   32'(freeze_pc),       32'd0);
    chk("rst_hazard",      32'(hazard_detected), 32'd0);
    chk("rst_flush",       32'(flush_if_id),     32'd0);
    chk("rst_freeze_back", 32'(freeze_back),     32'd0);
    chk("rst_halted",      32'(halted),          32'd0);
    chk("rst_stall_cnt",   32'(stall_cnt),       32'd0);
    do_reset();

    // Load-use with forwarding: one stall, then EXE advances and the MEM match is bypassed.
    cyc("lu_stall",   mk(5,0,0,1, 5,1,1, 0,0,1, 0,0), ex(1,1,0,1,0,0, 0,0));
    cyc("lu_advance", mk(5,0,0,1, 7,1,0, 5,1,1, 0,0), ex(0,0,0,0,0,0, 1,0));
    cyc("lu_idle",    idle,                           ex(0,0,0,0,0,0, 1,0));
    do_reset();

    // No forwarding: EXE match then MEM match on src2, advance in cycle 2.
    cyc("nf_exe",     mk(3,9,1,1, 9,1,0, 0,0,0, 0,0), ex(1,1,0,1,0,0, 0,0));
    cyc("nf_mem",     mk(3,9,1,1, 4,1,0, 9,1,0, 0,0), ex(1,1,0,1,0,0, 1,0));
    cyc("nf_advance", mk(3,9,1,1, 0,0,0, 4,1,0, 0,0), ex(0,0,0,0,0,0, 2,0));
    // Same pattern with destination register 0: no stall.
    cyc("nf_r0_exe",  mk(3,0,1,1, 0,1,0, 0,0,0, 0,0), ex(0,0,0,0,0,0, 2,0));
    cyc("nf_r0_mem",  mk(3,0,1,1, 4,0,0, 0,1,0, 0,0), ex(0,0,0,0,0,0, 2,0));
    // src2 match ignored when the instruction does not read src2.
    cyc("nf_one_src", mk(3,9,0,1, 9,1,0, 0,0,0, 0,0), ex(0,0,0,0,0,0, 2,0));
    do_reset();

    // Branch flush for one cycle, then branch under a RAW hazard stalls without flushing.
    cyc("br_flush",   mk(1,0,0,1, 0,0,0, 0,0,1, 1,0), ex(0,0,1,0,0,0, 0,0));
    cyc("br_after",   idle,                           ex(0,0,0,0,0,0, 0,1));
    cyc("br_raw",     mk(2,0,0,1, 2,1,0, 0,0,0, 1,0), ex(1,1,0,1,0,0, 0,1));
    cyc("br_raw_end", idle,                           ex(0,0,0,0,0,0, 1,1));
    do_reset();

    // Memory wait with a pending branch: four frozen cycles, flush on the fifth.
    cyc("mw_0", busy, ex(1,1,0,0,1,0, 0,0));
    cyc("mw_1", busy, ex(1,1,0,0,1,0, 1,0));
    cyc("mw_2", busy, ex(1,1,0,0,1,0, 2,0));
    cyc("mw_3", busy, ex(1,1,0,0,1,0, 3,0));
    cyc("mw_flush", mk(0,0,0,1, 0,0,0, 0,0,0, 1,0), ex(0,0,1,0,0,0, 4,0));
    cyc("mw_idle",  idle,                           ex(0,0,0,0,0,0, 4,1));
    do_reset();

    // Watchdog: eight frozen cycles, then sticky HALT after mem_busy drops.
    for (int i = 0; i < WDOG; i++) begin
      cyc("wd_frozen", busy, ex(1,1,0,0,1,0, i,0));
    end
    cyc("wd_halt_0", idle, ex(1,1,0,0,1,1, 8,0));
    cyc("wd_halt_1", idle, ex(1,1,0,0,1,1, 9,0));
    // Asynchronous reset mid-cycle clears HALT and counters without a clock edge.
    @(negedge clk);
    #2;
    drive(busy);
    rst = 1'b0;
    #1;
    chk("async_halted",    32'(halted),    32'd0);
    chk("async_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("async_freeze_pc", 32'(freeze_pc), 32'd0);
    chk("async_freeze_bk", 32'(freeze_back), 32'd0);
    #1;
    drive(idle);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc("wd_run_after_rst", idle, ex(0,0,0,0,0,0, 0,0));

    // Saturation: 20 frozen cycles in bursts of 5 with a watchdog break between bursts.
    do_reset();
    n = 0;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 5; k++) begin
        cyc("sat_frozen", busy, ex(1,1,0,0,1,0, (n > 15) ? 15 : n, 0));
        n++;
      end
      cyc("sat_break", idle, ex(0,0,0,0,0,0, (n > 15) ? 15 : n, 0));
    end
    cyc("sat_hold", idle, ex(0,0,0,0,0,0, 15, 0));

    // Drain the scoreboard with a bounded wait.
    t = 0;
    while (exp_q.size() > 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_sequencer.md
# pipe_hazard_sequencer

Pipeline stall/flush sequencer for the 5-stage MIPS core. It decides each cycle whether the decode-stage instruction may advance, must be held with a bubble injected into ID/EX, or must be flushed after a taken branch. It freezes the whole pipeline while data memory is busy and halts the core if a freeze never clears. It drives `hazard_detected` into the decode stage and the freeze/flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and keeps saturating performance counters.

## Interface
- `CNT_W`, 16: width of the performance counters.
- `WDOG_LIMIT`, 255: number of consecutive frozen cycles that trips the watchdog; the watchdog counter is `$clog2(WDOG_LIMIT+1)` bits wide.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `id_src1` in 5: decode source register 1.
- `id_src2` in 5: decode source register 2, as selected by the decode stage.
- `id_two_src` in 1: the decode instruction reads `id_src2` (register-type, store, or BNE).
- `id_valid` in 1: the decode stage holds a real instruction.
- `exe_dest` in 5, `exe_wb_en` in 1, `exe_mem_r_en` in 1: destination register, write-back enable and load flag of the instruction in EXE.
- `mem_dest` in 5, `mem_wb_en` in 1: destination register and write-back enable of the instruction in MEM.
- `fwd_en` in 1: forwarding unit is active.
- `br_taken` in 1: branch taken, resolved in decode.
- `mem_busy` in 1: data memory is not ready this cycle.
- `freeze_pc` out 1, `freeze_if_id` out 1: hold the PC / hold the IF/ID register.
- `flush_if_id` out 1: clear IF/ID to a NOP.
- `hazard_detected` out 1: decode stage emits a bubble into ID/EX.
- `freeze_back` out 1: hold the ID/EX, EX/MEM and MEM/WB registers.
- `halted` out 1: sticky watchdog error.
- `stall_cnt` out CNT_W, `flush_cnt` out CNT_W: performance counters.

## Operation
Register 0 never causes a hazard.

- **EXE match** = `exe_wb_en` && `exe_dest`≠0 && (`exe_dest`==`id_src1` || (`id_two_src` && `exe_dest`==`id_src2`)).
- **MEM match**: same rule using `mem_dest` / `mem_wb_en`.
- **raw_haz** = `id_valid` && (`fwd_en` ? (EXE match && `exe_mem_r_en`) : (EXE match || MEM match)).

States: RUN, HAZ_STALL, MEM_WAIT, HALT. Encoding is free. Decisions are applied in this priority order:
1. **HALT**: `freeze_pc` = `freeze_if_id` = `freeze_back` = 1 and `halted` = 1. The state is left only by reset.
2. **`mem_busy`**, in any non-HALT state: freeze_pc, freeze_if_id and freeze_back are all 1; `hazard_detected` = 0; `flush_if_id` = 0. Next state is MEM_WAIT.
3. **raw_haz**: freeze_pc = freeze_if_id = 1 and `hazard_detected` = 1. `br_taken` is ignored because its operands are stale. Next state is HAZ_STALL.
4. **`br_taken`**: `flush_if_id` = 1 for this cycle only. Next state is RUN.
5. **Otherwise**: all controls are 0. Next state is RUN.

HAZ_STALL and MEM_WAIT evaluate the same priority list every cycle. They exist to drive the watchdog and for debug visibility.

Counters:
- `stall_cnt` increments on every cycle with `freeze_pc` = 1, including HALT.
- `flush_cnt` increments on every cycle with `flush_if_id` = 1.
- Both saturate at 2^CNT_W − 1 and do not wrap.

Watchdog:
- `wd_cnt` increments on every cycle in which `freeze_pc` = 1, outside HALT.
- It clears on any cycle with `freeze_pc` = 0.
- When `wd_cnt` == WDOG_LIMIT−1 and `freeze_pc` = 1, the next state is HALT (the LIMIT-th consecutive frozen cycle).

## Timing
- Control outputs are combinational from the current state and the current inputs (Mealy), with zero-cycle latency.
- State, counters and `wd_cnt` update on the rising edge of `clk`.
- While `rst` = 0: state = RUN, all counters = 0, `halted` = 0. All control outputs are forced to 0 regardless of inputs.
- Reset asserted mid-stall or in HALT returns the block to RUN asynchronously.
- Load-use with forwarding: exactly 1 stall cycle, then the load has moved to MEM and the EXE match clears.
- Without forwarding: up to 2 stall cycles (EXE match, then MEM match).
- Branch flush: a single cycle. The flushed IF/ID slot arrives at decode with `id_valid` = 0, so no repeat flush occurs.
- `mem_busy` together with `br_taken`: freeze wins and there is no flush. The branch stays frozen in decode and flushes on the first cycle after `mem_busy` falls, provided no raw_haz exists then.

## Test plan
- **Load-use, forwarding on.** Stimulus: `fwd_en` = 1, `exe_mem_r_en` = 1, `exe_dest` = 5, `id_src1` = 5 for 1 cycle, then EXE advances. Required: `hazard_detected`, `freeze_pc` and `freeze_if_id` high for exactly 1 cycle; `stall_cnt` = 1.
- **No forwarding, two-stage RAW.** Stimulus: `fwd_en` = 0, `id_two_src` = 1, `id_src2` = 9 matching `exe_dest` = 9 in cycle 0, then `mem_dest` = 9 in cycle 1. Required: 2 stall cycles, `stall_cnt` = 2, advance in cycle 2. The same pattern with dest = 0 produces no stall.
- **Branch.** Stimulus: `br_taken` = 1 for 1 cycle, no hazard. Required: `flush_if_id` = 1 for 1 cycle; `flush_cnt` = 1; no freeze. Then `br_taken` together with raw_haz: no flush, stall only.
- **Memory wait with pending branch.** Stimulus: `mem_busy` = 1 for 4 cycles while `br_taken` = 1. Required: all three freezes high for 4 cycles with `flush_if_id` = 0, then `flush_if_id` = 1 in cycle 5; `stall_cnt` = 4.
- **Watchdog, WDOG_LIMIT = 8.** Stimulus: `mem_busy` held high. Required: `halted` rises after 8 frozen cycles and stays high after `mem_busy` drops. Asserting `rst` low clears `halted`, the counters and the state to RUN immediately, without waiting for a clock edge.
- **Saturation, CNT_W = 4.** Stimulus: 20 stall cycles, with a watchdog break every 5 cycles. Required: `stall_cnt` holds at 15.
